// File: rtl/avalon_capture_pio.sv
// avalon_capture_pio: multi-channel Avalon-MM input PIO. Each channel passes
// through a synchroniser, then feeds per-bit edge capture (W1C), an irq mask,
// and an atomic all-channel snapshot.
//
// Ports:
//   clk, reset_n           system clock, asynchronous active-low reset
//   address[AW-1:0]        [AW-1:2] channel, [1:0] register
//                          (0 DATA, 1 MASK, 2 EDGECAP, 3 SNAP)
//   chipselect/read/write  Avalon-MM strobes
//   writedata[31:0]        write data, bits [WIDTH-1:0] used
//   readdata[31:0]         registered read data, latency 1, zero-extended
//   in_port                external inputs, channel c = [c*WIDTH +: WIDTH]
//   irq                    level interrupt, OR of (edgecap & mask)
module avalon_capture_pio #(
  parameter int  WIDTH       = 32,
  parameter int  CHANNELS    = 2,
  parameter int  EDGE_TYPE   = 0,
  parameter int  SYNC_STAGES = 2,
  localparam int AW          = $clog2(CHANNELS) + 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [AW-1:0]             address,
  input  logic                      chipselect,
  input  logic                      read,
  input  logic                      write,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic [CHANNELS*WIDTH-1:0] in_port,
  output logic                      irq
);

  localparam int NB = CHANNELS * WIDTH;

  logic [NB-1:0] sync_pipe [SYNC_STAGES];
  logic [NB-1:0] sync_q;
  logic [NB-1:0] prev_q;
  logic [NB-1:0] edge_det;
  logic [NB-1:0] edgecap_q, edgecap_d;
  logic [NB-1:0] mask_q, mask_d;
  logic [NB-1:0] snap_q;
  logic [AW-1:0] ch_sel;
  logic [1:0]    reg_sel;
  logic          in_range;
  logic          wr_en;
  logic          rd_en;
  logic          snap_wr;
  logic [31:0]   rd_word;
  logic          unused_wdata;

  assign sync_q   = sync_pipe[SYNC_STAGES-1];
  // Shift rather than slice so CHANNELS=1 (AW=2) still yields channel 0.
  assign ch_sel   = address >> 2;
  assign reg_sel  = address[1:0];
  assign in_range = (ch_sel < AW'(CHANNELS));
  assign wr_en    = chipselect & write & in_range;
  assign rd_en    = chipselect & read;
  assign snap_wr  = wr_en & (reg_sel == 2'd3);
  assign unused_wdata = ^writedata;

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_det = sync_q & ~prev_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_det = ~sync_q & prev_q;
    end else begin : g_any
      assign edge_det = sync_q ^ prev_q;
    end
  endgenerate

  // A new edge is OR-ed in after the W1C clear so it wins a same-cycle collision.
  always_comb begin
    mask_d    = mask_q;
    edgecap_d = edgecap_q | edge_det;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (wr_en && (ch_sel == AW'(c))) begin
        if (reg_sel == 2'd1) begin
          mask_d[c*WIDTH +: WIDTH] = writedata[WIDTH-1:0];
        end
        if (reg_sel == 2'd2) begin
          edgecap_d[c*WIDTH +: WIDTH] =
            (edgecap_q[c*WIDTH +: WIDTH] & ~writedata[WIDTH-1:0]) |
            edge_det[c*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Out-of-range channels match no c, leaving rd_word at zero.
  always_comb begin
    rd_word = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (ch_sel == AW'(c)) begin
        case (reg_sel)
          2'd0:    rd_word[WIDTH-1:0] = sync_q[c*WIDTH +: WIDTH];
          2'd1:    rd_word[WIDTH-1:0] = mask_q[c*WIDTH +: WIDTH];
          2'd2:    rd_word[WIDTH-1:0] = edgecap_q[c*WIDTH +: WIDTH];
          default: rd_word[WIDTH-1:0] = snap_q[c*WIDTH +: WIDTH];
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        sync_pipe[s] <= '0;
      end
      prev_q    <= '0;
      edgecap_q <= '0;
      mask_q    <= '0;
      snap_q    <= '0;
      readdata  <= '0;
    end else begin
      sync_pipe[0] <= in_port;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        sync_pipe[s] <= sync_pipe[s-1];
      end
      prev_q    <= sync_q;
      edgecap_q <= edgecap_d;
      mask_q    <= mask_d;
      if (snap_wr) begin
        snap_q <= sync_q;
      end
      if (rd_en) begin
        readdata <= rd_word;
      end
    end
  end

  assign irq = |(edgecap_q & mask_q);

endmodule

// File: tb/tb_avalon_capture_pio.sv
// Testbench for avalon_capture_pio. Two instances share one Avalon bus:
//   u_a: WIDTH=32, CHANNELS=2, rising edges, 2 sync stages
//   u_b: WIDTH=16, CHANNELS=3, any edge, 3 sync stages (zero-extension,
//        out-of-range channel 3 at address 12..15)
// u_a sees address[2:0]; u_b sees the full 4-bit address.
module tb_avalon_capture_pio;

  localparam int W0 = 32, C0 = 2, S0 = 2;
  localparam int W1 = 16, C1 = 3, S1 = 3;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] OFF  = 32'h0000_0050;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [3:0]          address;
  logic                chipselect, read, write;
  logic [31:0]         writedata;
  logic [C0*W0-1:0]    in_a;
  logic [C1*W1-1:0]    in_b;
  logic [31:0]         rd_a, rd_b;
  logic                irq_a, irq_b;

  always #5 clk = ~clk;

  avalon_capture_pio #(.WIDTH(W0), .CHANNELS(C0), .EDGE_TYPE(0), .SYNC_STAGES(S0)) u_a (
    .clk(clk), .reset_n(reset_n), .address(address[2:0]), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(rd_a),
    .in_port(in_a), .irq(irq_a));

  avalon_capture_pio #(.WIDTH(W1), .CHANNELS(C1), .EDGE_TYPE(2), .SYNC_STAGES(S1)) u_b (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(rd_b),
    .in_port(in_b), .irq(irq_b));

  typedef struct {
    logic [3:0]  addr;
    string       name;
    logic [31:0] exp_a;
    bit          chk_a;
    logic [31:0] exp_b;
    bit          chk_b;
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // Read monitor: one cycle after the strobe edge, pop and compare.
  always @(posedge clk) begin : mon
    vec_t e;
    if (chipselect && read) begin
      #1;
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.chk_a) check({e.name, "_a"}, rd_a, e.exp_a);
        if (e.chk_b) check({e.name, "_b"}, rd_b, e.exp_b);
      end
    end
  end

  task automatic rdv(input vec_t v);
    @(negedge clk);
    address = v.addr; chipselect = 1'b1; read = 1'b1; write = 1'b0;
    sb_q.push_back(v);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input string n, input logic [31:0] ea,
                    input bit ca, input logic [31:0] eb, input bit cb);
    vec_t v;
    v = '{addr: a, name: n, exp_a: ea, chk_a: ca, exp_b: eb, chk_b: cb};
    rdv(v);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write = 1'b1; read = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [31:0] v;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0;
    in_a = {32'hDEAD_BEEF, 32'h0000_1234};
    in_b = {16'hCAFE, 16'h0F0F, 16'hBEEF};

    // 1. reset state and read sweep
    repeat (3) @(negedge clk);
    check("rst_readdata_a", rd_a, 32'h0);
    check("rst_readdata_b", rd_b, 32'h0);
    check("rst_irq_a", {31'h0, irq_a}, 32'h0);
    check("rst_irq_b", {31'h0, irq_b}, 32'h0);
    reset_n = 1'b1;
    repeat (S1 + 1) @(negedge clk);

    vecs.push_back('{addr: 4'd0,  name: "data_ch0",  exp_a: 32'h0000_1234, chk_a: 1, exp_b: 32'h0000_BEEF, chk_b: 1});
    vecs.push_back('{addr: 4'd4,  name: "data_ch1",  exp_a: 32'hDEAD_BEEF, chk_a: 1, exp_b: 32'h0000_0F0F, chk_b: 1});
    vecs.push_back('{addr: 4'd8,  name: "data_ch2",  exp_a: 32'h0000_1234, chk_a: 1, exp_b: 32'h0000_CAFE, chk_b: 1});
    vecs.push_back('{addr: 4'd12, name: "oor_data",  exp_a: 32'hDEAD_BEEF, chk_a: 1, exp_b: 32'h0,         chk_b: 1});
    vecs.push_back('{addr: 4'd15, name: "oor_snap",  exp_a: 32'h0,         chk_a: 1, exp_b: 32'h0,         chk_b: 1});
    vecs.push_back('{addr: 4'd1,  name: "mask_rst",  exp_a: 32'h0,         chk_a: 1, exp_b: 32'h0,         chk_b: 1});
    vecs.push_back('{addr: 4'd3,  name: "snap_rst",  exp_a: 32'h0,         chk_a: 1, exp_b: 32'h0,         chk_b: 1});
    vecs.push_back('{addr: 4'd5,  name: "mask1_rst", exp_a: 32'h0,         chk_a: 1, exp_b: 32'h0,         chk_b: 1});
    foreach (vecs[i]) rdv(vecs[i]);

    // Clear whatever the post-reset fill captured, then probe MASK width.
    wr(4'd2, 32'hFFFF_FFFF);
    wr(4'd6, 32'hFFFF_FFFF);
    wr(4'd10, 32'hFFFF_FFFF);
    wr(4'd1, 32'hFFFF_FFFF);
    rd(4'd1, "mask_zext", 32'hFFFF_FFFF, 1, 32'h0000_FFFF, 1);
    check("irq_no_edge", {31'h0, irq_a}, 32'h0);

    // 2. rising edge capture and irq latency
    wr(4'd1, 32'h1);
    in_a[0] = 1'b1;
    for (int e = 1; e <= S0 + 1; e++) begin
      @(posedge clk); #1;
      check($sformatf("irq_lat_edge%0d", e), {31'h0, irq_a}, (e == S0 + 1) ? 32'h1 : 32'h0);
    end
    rd(4'd2, "edgecap_bit0", 32'h1, 1, 32'h0, 0);
    check("irq_before_clr", {31'h0, irq_a}, 32'h1);
    wr(4'd2, 32'h1);
    check("irq_after_clr", {31'h0, irq_a}, 32'h0);
    rd(4'd2, "edgecap_cleared", 32'h0, 1, 32'h0, 0);

    // 3. unmasked edge, then mask it in, then mask it out
    in_a[3] = 1'b1;
    repeat (S0 + 2) @(negedge clk);
    check("irq_unmasked", {31'h0, irq_a}, 32'h0);
    rd(4'd2, "edgecap_bit3", 32'h8, 1, 32'h0, 0);
    wr(4'd1, 32'h8);
    check("irq_masked_in", {31'h0, irq_a}, 32'h1);
    wr(4'd1, 32'h0);
    check("irq_masked_out", {31'h0, irq_a}, 32'h0);
    rd(4'd2, "edgecap_kept", 32'h8, 1, 32'h0, 0);
    wr(4'd2, 32'hFFFF_FFFF);

    // 4. falling edge ignored by rising DUT; then W1C colliding with a new edge
    in_a[0] = 1'b0;
    repeat (S0 + 2) @(negedge clk);
    rd(4'd2, "no_fall_capture", 32'h0, 1, 32'h0, 0);
    in_a[0] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    wr(4'd2, 32'h1);  // lands on the edge that sets bit0
    rd(4'd2, "collision_edge_wins", 32'h1, 1, 32'h0, 0);

    // 5. snapshot of free-running counters; write at i=6 snaps values set at i=4
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      v = BASE + 32'(i);
      in_a = {v + OFF, v};
      if (i == 6) begin
        address = 4'd7; writedata = 32'h0; chipselect = 1'b1; write = 1'b1;
      end else begin
        chipselect = 1'b0; write = 1'b0;
      end
    end
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
    rd(4'd3, "snap_ch0", BASE + 32'd4, 1, 32'h0000_BEEF, 1);
    rd(4'd7, "snap_ch1", BASE + 32'd4 + OFF, 1, 32'h0000_0F0F, 1);
    rd(4'd0, "data_after_snap", BASE + 32'd11, 1, 32'h0000_BEEF, 1);
    in_b[15:0] = 16'h1111;
    repeat (S1 + 2) @(negedge clk);
    wr(4'd15, 32'h0);  // u_a: ch1 SNAP; u_b: channel 3, ignored
    rd(4'd3, "oor_write_ignored", BASE + 32'd11, 1, 32'h0000_BEEF, 1);

    // 6. any-edge capture on u_b, then asynchronous reset mid-stream
    wr(4'd2, 32'hFFFF_FFFF);
    wr(4'd1, 32'h1);
    check("irq_b_pre_fall", {31'h0, irq_b}, 32'h0);
    in_b[0] = 1'b0;
    repeat (S1 + 2) @(negedge clk);
    check("irq_b_fall", {31'h0, irq_b}, 32'h1);
    rd(4'd2, "edgecap_any_fall", 32'h0, 1, 32'h1, 1);
    rd(4'd3, "snap_pre_rst", BASE + 32'd11, 1, 32'h0000_BEEF, 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    in_a = '0;
    in_b = '0;
    #1;
    check("midrst_readdata_a", rd_a, 32'h0);
    check("midrst_readdata_b", rd_b, 32'h0);
    check("midrst_irq_b", {31'h0, irq_b}, 32'h0);
    check("midrst_irq_a", {31'h0, irq_a}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    rd(4'd0, "post_rst_data", 32'h0, 1, 32'h0, 1);
    rd(4'd1, "post_rst_mask", 32'h0, 1, 32'h0, 1);
    rd(4'd2, "post_rst_edgecap", 32'h0, 1, 32'h0, 1);
    rd(4'd3, "post_rst_snap", 32'h0, 1, 32'h0, 1);

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
